// File: rtl/ft601_tx_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : ft601_tx_mux_if
//  Description : Producer-side and FT601-side signal bundle for ft601_tx_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ft601_tx_mux_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    logic [NUM_CH*(DATA_W+BE_W)-1:0] in_data;
    logic [NUM_CH-1:0]               in_valid;
    logic [NUM_CH-1:0]               in_push;
    logic [NUM_CH-1:0]               in_afull;
    logic [NUM_CH-1:0]               in_busy;
    logic [NUM_CH-1:0]               in_ovf;
    logic                            ft_txe_n;
    logic                            ft_wr_n;
    logic [DATA_W-1:0]               ft_data;
    logic [BE_W-1:0]                 ft_be;
    logic                            ft_oe;

    modport master (
        output in_data, in_valid, in_push, ft_txe_n,
        input  in_afull, in_busy, in_ovf, ft_wr_n, ft_data, ft_be, ft_oe
    );

    modport slave (
        input  in_data, in_valid, in_push, ft_txe_n,
        output in_afull, in_busy, in_ovf, ft_wr_n, ft_data, ft_be, ft_oe
    );
endinterface
`default_nettype wire

// File: rtl/ft601_tx_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ft601_tx_mux
//  Description : Per-channel FIFOs with round-robin arbitration, emitting
//                framed bursts (header + payload) on the FT601 245 write bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module ft601_tx_mux #(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 32,
    parameter int BE_W         = DATA_W / 8,
    parameter int DEPTH        = 512,
    parameter int BURST_MAX    = 256,
    parameter int AFULL_MARGIN = 8
) (
    input  logic           clk,
    input  logic           reset,
    ft601_tx_mux_if.slave  bus
);
    localparam int c_WORD_W = DATA_W + BE_W;
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_LVL_W  = c_PTR_W + 1;
    localparam int c_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_LVL_W-1:0] c_DEPTH_L = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_BURST_L = c_LVL_W'(BURST_MAX);
    localparam logic [c_LVL_W-1:0] c_AFULL_L = c_LVL_W'(DEPTH - AFULL_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_HDR2 = 3'd2,
        S_DATA = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    logic [c_WORD_W-1:0] r_mem    [NUM_CH][DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr [NUM_CH];
    logic [c_PTR_W-1:0]  r_rd_ptr [NUM_CH];
    logic [c_LVL_W-1:0]  r_level  [NUM_CH];
    logic [7:0]          r_seq    [NUM_CH];
    logic [NUM_CH-1:0]   r_ovf;
    logic [NUM_CH-1:0]   r_flush;

    state_t              r_state, w_state_nxt;
    logic [c_CH_W-1:0]   r_grant, w_grant_nxt;
    logic [c_CH_W-1:0]   r_rr, w_rr_nxt;
    logic [15:0]         r_len, w_len_nxt;
    logic [15:0]         r_remain, w_remain_nxt;
    logic                r_drain, w_drain_nxt;
    logic                r_wr_n, w_wr_n_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [BE_W-1:0]     r_be, w_be_nxt;

    logic [c_WORD_W-1:0] w_in_word [NUM_CH];
    logic [NUM_CH-1:0]   w_full, w_elig, w_wr, w_pop, w_afull;
    logic                w_done, w_xfer, w_any;
    logic [c_CH_W-1:0]   w_pick;
    logic [c_LVL_W-1:0]  w_pick_lvl;
    logic [15:0]         w_pick_len;
    logic [31:0]         w_hdr;
    logic [c_WORD_W-1:0] w_head;
    int                  v_dist, v_best;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_in_word[g]    = bus.in_data[g*c_WORD_W +: c_WORD_W];
            assign w_full[g]       = (r_level[g] == c_DEPTH_L);
            assign w_elig[g]       = (r_level[g] >= c_BURST_L) || (r_flush[g] && (r_level[g] != '0));
            // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
            assign w_wr[g]         = bus.in_valid[g] && (!w_full[g] || w_pop[g]);
            assign w_afull[g]      = (r_level[g] >= c_AFULL_L);
            assign bus.in_afull[g] = w_afull[g];
            assign bus.in_busy[g]  = w_afull[g] | r_flush[g];
        end
    endgenerate

    assign bus.in_ovf  = r_ovf;
    assign bus.ft_wr_n = r_wr_n;
    assign bus.ft_oe   = !r_wr_n;
    assign bus.ft_data = r_data;
    assign bus.ft_be   = r_be;

    assign w_xfer     = !r_wr_n && !bus.ft_txe_n;
    assign w_head     = r_mem[r_grant][r_rd_ptr[r_grant]];
    assign w_pick_lvl = r_level[w_pick];
    assign w_pick_len = (w_pick_lvl >= c_BURST_L) ? 16'(BURST_MAX) : 16'(w_pick_lvl);
    assign w_hdr      = {4'hA, 4'(w_pick), r_seq[w_pick], w_pick_len};

    // Round-robin: smallest distance after the last served channel wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr;
        v_best = NUM_CH;
        v_dist = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            v_dist = c - int'(r_rr) - 1;
            if (v_dist < 0) v_dist = v_dist + NUM_CH;
            if (w_elig[c] && (v_dist < v_best)) begin
                v_best = v_dist;
                w_pick = c_CH_W'(c);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_nxt     = r_rr;
        w_len_nxt    = r_len;
        w_remain_nxt = r_remain;
        w_drain_nxt  = r_drain;
        w_wr_n_nxt   = r_wr_n;
        w_data_nxt   = r_data;
        w_be_nxt     = r_be;
        w_pop        = '0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt  = w_pick;
                    w_len_nxt    = w_pick_len;
                    w_remain_nxt = w_pick_len;
                    w_drain_nxt  = (w_pick_lvl <= c_BURST_L);
                    w_wr_n_nxt   = 1'b0;
                    // Narrow bus sends the upper header half first.
                    w_data_nxt   = DATA_W'(w_hdr >> (32 - DATA_W));
                    w_be_nxt     = '1;
                    w_state_nxt  = S_HDR;
                end
            end
            S_HDR: begin
                if (w_xfer) begin
                    if (DATA_W < 32) begin
                        w_data_nxt  = DATA_W'(r_len);
                        w_state_nxt = S_HDR2;
                    end else begin
                        w_data_nxt       = w_head[DATA_W-1:0];
                        w_be_nxt         = w_head[c_WORD_W-1:DATA_W];
                        w_pop[r_grant]   = 1'b1;
                        w_state_nxt      = S_DATA;
                    end
                end
            end
            S_HDR2: begin
                if (w_xfer) begin
                    w_data_nxt     = w_head[DATA_W-1:0];
                    w_be_nxt       = w_head[c_WORD_W-1:DATA_W];
                    w_pop[r_grant] = 1'b1;
                    w_state_nxt    = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    if (r_remain == 16'd1) begin
                        w_wr_n_nxt  = 1'b1;
                        w_done      = 1'b1;
                        w_rr_nxt    = r_grant;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_remain_nxt   = r_remain - 16'd1;
                        w_data_nxt     = w_head[DATA_W-1:0];
                        w_be_nxt       = w_head[c_WORD_W-1:DATA_W];
                        w_pop[r_grant] = 1'b1;
                    end
                end
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr     <= '0;
            r_len    <= '0;
            r_remain <= '0;
            r_drain  <= 1'b0;
            r_wr_n   <= 1'b1;
            r_data   <= '0;
            r_be     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr     <= w_rr_nxt;
            r_len    <= w_len_nxt;
            r_remain <= w_remain_nxt;
            r_drain  <= w_drain_nxt;
            r_wr_n   <= w_wr_n_nxt;
            r_data   <= w_data_nxt;
            r_be     <= w_be_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf   <= '0;
            r_flush <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_level[c]  <= '0;
                r_seq[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                if (w_pop[c]) r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                if (w_wr[c] && !w_pop[c])
                    r_level[c] <= r_level[c] + 1'b1;
                else if (!w_wr[c] && w_pop[c])
                    r_level[c] <= r_level[c] - 1'b1;
                if (bus.in_valid[c] && !w_wr[c]) r_ovf[c] <= 1'b1;
                if (bus.in_push[c])
                    r_flush[c] <= 1'b1;
                else if (w_done && r_drain && (r_grant == c_CH_W'(c)))
                    r_flush[c] <= 1'b0;
                if (w_done && (r_grant == c_CH_W'(c))) r_seq[c] <= r_seq[c] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr[c]) r_mem[c][r_wr_ptr[c]] <= w_in_word[c];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ft601_tx_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ft601_tx_mux
//  Description : Directed self-checking bench for ft601_tx_mux (2 ch, 32-bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ft601_tx_mux;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int W      = DATA_W + BE_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ft601_tx_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

    ft601_tx_mux #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BE_W(BE_W),
        .DEPTH(512), .BURST_MAX(256), .AFULL_MARGIN(8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int wr_low   = 0;
    logic [W-1:0] log_q[$];
    logic [W-1:0] exp_q[$];

    // Bus words are logged on the falling edge preceding the accepting rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.ft_wr_n) wr_low++;
            if (!bus.ft_wr_n && !bus.ft_txe_n) log_q.push_back({bus.ft_be, bus.ft_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_ch(input int ch, input logic [31:0] base, input int n, input logic [3:0] be);
        for (int i = 0; i < n; i++) begin
            bus.in_data[ch*W +: W] = {be, base + 32'(i)};
            bus.in_valid[ch] = 1'b1;
            tick;
        end
        bus.in_valid[ch] = 1'b0;
    endtask

    task automatic push_ch(input int ch);
        bus.in_push[ch] = 1'b1;
        tick;
        bus.in_push[ch] = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick;
            k++;
        end
        if (log_q.size() < n) check(tag, 64'(log_q.size()), 64'(n));
    endtask

    task automatic check_stream(input string tag);
        int bad = 0;
        check({tag, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i] !== exp_q[i]) bad++;
        check({tag, "_bad_words"}, 64'(bad), 64'd0);
    endtask

    task automatic exp_payload(input logic [31:0] base, input int n, input logic [3:0] be);
        for (int i = 0; i < n; i++) exp_q.push_back({be, base + 32'(i)});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data  = '0;
        bus.in_valid = '0;
        bus.in_push  = '0;
        bus.ft_txe_n = 1'b1;
        repeat (3) tick;
        reset = 1'b0;

        check("rst_wr_n",  64'(bus.ft_wr_n),  64'd1);
        check("rst_oe",    64'(bus.ft_oe),    64'd0);
        check("rst_data",  64'(bus.ft_data),  64'd0);
        check("rst_be",    64'(bus.ft_be),    64'd0);
        check("rst_afull", 64'(bus.in_afull), 64'd0);
        check("rst_busy",  64'(bus.in_busy),  64'd0);
        check("rst_ovf",   64'(bus.in_ovf),   64'd0);

        // Full burst on ch0.
        bus.ft_txe_n = 1'b0;
        log_q.delete(); exp_q.delete(); wr_low = 0;
        write_ch(0, 32'h0, 256, 4'hF);
        wait_log("full_wait", 257, 600);
        repeat (4) tick;
        check("full_hdr", 64'(log_q[0]), 64'h0F_A000_0100);
        exp_q.push_back(36'hF_A000_0100);
        exp_payload(32'h0, 256, 4'hF);
        check_stream("full");
        check("full_wr_low", 64'(wr_low), 64'd257);

        // Short flushed burst on ch0 shows the incremented sequence number.
        log_q.delete(); exp_q.delete();
        write_ch(0, 32'h50, 3, 4'hF);
        push_ch(0);
        wait_log("seq_wait", 4, 100);
        repeat (4) tick;
        check("seq_hdr", 64'(log_q[0]), 64'h0F_A001_0003);
        exp_q.push_back(36'hF_A001_0003);
        exp_payload(32'h50, 3, 4'hF);
        check_stream("seq");

        // Flush on ch1 with varying byte enables.
        log_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) write_ch(1, 32'h100 + 32'(i), 1, 4'(i + 1));
        push_ch(1);
        check("flush_busy_set", 64'(bus.in_busy[1]), 64'd1);
        wait_log("flush_wait", 6, 100);
        repeat (3) tick;
        check("flush_hdr", 64'(log_q[0]), 64'h0F_A100_0005);
        exp_q.push_back(36'hF_A100_0005);
        for (int i = 0; i < 5; i++) exp_q.push_back({4'(i + 1), 32'h100 + 32'(i)});
        check_stream("flush");
        check("flush_busy_clr", 64'(bus.in_busy[1]), 64'd0);

        // Round-robin with both channels loaded, plus a mid-payload stall.
        bus.ft_txe_n = 1'b1;
        log_q.delete(); exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            bus.in_data[0 +: W] = {4'hF, 32'h1000 + 32'(i)};
            bus.in_data[W +: W] = {4'hF, 32'h2000 + 32'(i)};
            bus.in_valid = 2'b11;
            tick;
        end
        bus.in_valid = 2'b00;
        write_ch(0, 32'h1100, 256, 4'hF);
        check("rr_afull0", 64'(bus.in_afull[0]), 64'd1);
        check("rr_ovf0",   64'(bus.in_ovf[0]),   64'd0);
        bus.ft_txe_n = 1'b0;
        wait_log("rr_stall_wait", 50, 200);
        bus.ft_txe_n = 1'b1;
        check("bp_data_at_stall", 64'(bus.ft_data), 64'h1031);
        repeat (10) tick;
        check("bp_data_held", 64'(bus.ft_data), 64'h1031);
        check("bp_wr_n_held", 64'(bus.ft_wr_n), 64'd0);
        bus.ft_txe_n = 1'b0;
        wait_log("rr_wait", 771, 1200);
        repeat (4) tick;
        check("rr_hdr0", 64'(log_q[0]),   64'h0F_A002_0100);
        check("rr_hdr1", 64'(log_q[257]), 64'h0F_A101_0100);
        check("rr_hdr2", 64'(log_q[514]), 64'h0F_A003_0100);
        exp_q.push_back(36'hF_A002_0100);
        exp_payload(32'h1000, 256, 4'hF);
        exp_q.push_back(36'hF_A101_0100);
        exp_payload(32'h2000, 256, 4'hF);
        exp_q.push_back(36'hF_A003_0100);
        exp_payload(32'h1100, 256, 4'hF);
        check_stream("rr");

        // Overflow on ch1 while the FT side is stalled.
        bus.ft_txe_n = 1'b1;
        log_q.delete(); exp_q.delete();
        for (int i = 0; i < 513; i++) begin
            bus.in_data[W +: W] = {4'hF, 32'h3000 + 32'(i)};
            bus.in_valid[1] = 1'b1;
            tick;
            if (i == 502) check("ovf_afull_503", 64'(bus.in_afull[1]), 64'd0);
            if (i == 503) check("ovf_afull_504", 64'(bus.in_afull[1]), 64'd1);
            if (i == 511) check("ovf_flag_512",  64'(bus.in_ovf[1]),   64'd0);
        end
        bus.in_valid[1] = 1'b0;
        check("ovf_flag_513", 64'(bus.in_ovf[1]), 64'd1);
        bus.ft_txe_n = 1'b0;
        wait_log("ovf_wait", 514, 1000);
        repeat (5) tick;
        check("ovf_hdr0", 64'(log_q[0]),   64'h0F_A102_0100);
        check("ovf_hdr1", 64'(log_q[257]), 64'h0F_A103_0100);
        exp_q.push_back(36'hF_A102_0100);
        exp_payload(32'h3000, 256, 4'hF);
        exp_q.push_back(36'hF_A103_0100);
        exp_payload(32'h3100, 256, 4'hF);
        check_stream("ovf");
        check("ovf_afull_drained", 64'(bus.in_afull[1]), 64'd0);
        check("ovf_sticky",        64'(bus.in_ovf[1]),   64'd1);

        // Reset in the middle of a payload.
        log_q.delete(); exp_q.delete();
        write_ch(0, 32'h4000, 256, 4'hF);
        wait_log("mid_wait", 101, 200);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_wr_n",  64'(bus.ft_wr_n),  64'd1);
        check("mid_rst_oe",    64'(bus.ft_oe),    64'd0);
        check("mid_rst_ovf",   64'(bus.in_ovf),   64'd0);
        check("mid_rst_afull", 64'(bus.in_afull), 64'd0);
        check("mid_rst_busy",  64'(bus.in_busy),  64'd0);
        repeat (3) tick;
        log_q.delete();
        write_ch(0, 32'h5000, 2, 4'hF);
        push_ch(0);
        wait_log("post_rst_wait", 3, 100);
        repeat (5) tick;
        check("post_rst_hdr", 64'(log_q[0]), 64'h0F_A000_0002);
        exp_q.push_back(36'hF_A000_0002);
        exp_payload(32'h5000, 2, 4'hF);
        check_stream("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
